phase_sequencer: RTL

//   Parametrised multi-approach traffic-light sequencer with an integrated 1 Hz prescaler,
//   per-interval programmable durations, sensor-driven green extension and a latched

---
 rtl/phase_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// Multi-approach traffic-light sequencer: 1 Hz prescaler, programmable interval durations,
// sensor-driven single green extension and a latched pedestrian walk phase.
module phase_sequencer #(
  parameter int unsigned NUM_PHASES = 2,
  parameter int unsigned TW         = 4,
  parameter int unsigned CLK_DIV    = 100000000,
  parameter int unsigned DEF_BASE   = 6,
  parameter int unsigned DEF_EXT    = 3,
  parameter int unsigned DEF_YEL    = 2,
  parameter int unsigned DEF_WALK   = 3,
  localparam int unsigned PW        = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PHASES-1:0] sensor,
  input  logic                  walk_req,
  input  logic                  restart,
  input  logic                  prog_we,
  input  logic [1:0]            prog_sel,
  input  logic [TW-1:0]         prog_val,
  output logic [NUM_PHASES-1:0] green,
  output logic [NUM_PHASES-1:0] yellow,
  output logic [NUM_PHASES-1:0] red,
  output logic                  walk_led,
  output logic [PW-1:0]         phase
);

  localparam int unsigned CW   = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LastPhase = PW'(NUM_PHASES - 1);

  typedef enum logic [1:0] {StGreen, StExt, StYellow, StWalk} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [TW-1:0]           rem_q, rem_d;
  logic                    walk_pend_q, walk_pend_d;
  logic [TW-1:0]           base_q, ext_q, yel_q, walk_q;
  logic [NUM_PHASES-1:0]   green_q, green_d, yellow_q, yellow_d;
  logic                    walk_led_q, walk_led_d;

  logic                    tick, expire, enter;
  logic [TW-1:0]           load_val;

  assign tick   = (cnt_q == CW'(CLK_DIV - 1));
  assign expire = tick && (rem_q == TW'(1));

  // Next-state, timer reload and lamp decode
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = tick ? '0 : cnt_q + CW'(1);
    rem_d       = rem_q;
    enter       = 1'b0;
    load_val    = '0;
    green_d     = '0;
    yellow_d    = '0;
    walk_led_d  = 1'b0;

    if (tick && !expire) begin
      rem_d = rem_q - TW'(1);
    end

    if (restart) begin
      state_d  = StGreen;
      phase_d  = '0;
      enter    = 1'b1;
      load_val = base_q;
    end else if (expire) begin
      enter = 1'b1;
      unique case (state_q)
        StGreen: begin
          if (sensor[phase_q]) begin
            state_d  = StExt;
            load_val = ext_q;
          end else begin
            state_d  = StYellow;
            load_val = yel_q;
          end
        end
        StExt: begin
          state_d  = StYellow;
          load_val = yel_q;
        end
        StYellow: begin
          if (walk_pend_q && (phase_q == LastPhase)) begin
            state_d  = StWalk;
            load_val = walk_q;
          end else begin
            state_d  = StGreen;
            phase_d  = (phase_q == LastPhase) ? '0 : phase_q + PW'(1);
            load_val = base_q;
          end
        end
        StWalk: begin
          state_d  = StGreen;
          phase_d  = '0;
          load_val = base_q;
        end
        default: begin
          state_d  = StGreen;
          phase_d  = '0;
          load_val = base_q;
        end
      endcase
    end

    // A programmed zero behaves as a one-second interval
    if (enter) begin
      cnt_d = '0;
      rem_d = (load_val == '0) ? TW'(1) : load_val;
    end

    // A request coincident with walk entry is absorbed by that walk
    if (enter && (state_d == StWalk)) begin
      walk_pend_d = 1'b0;
    end else begin
      walk_pend_d = walk_req | walk_pend_q;
    end

    unique case (state_d)
      StGreen, StExt: green_d  = NUM_PHASES'(1) << phase_d;
      StYellow:       yellow_d = NUM_PHASES'(1) << phase_d;
      StWalk:         walk_led_d = 1'b1;
      default:        green_d  = NUM_PHASES'(1);
    endcase
  end

  // Sequencer state, timer and registered lamps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StGreen;
      phase_q     <= '0;
      cnt_q       <= '0;
      rem_q       <= TW'(DEF_BASE);
      walk_pend_q <= 1'b0;
      green_q     <= NUM_PHASES'(1);
      yellow_q    <= '0;
      walk_led_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      walk_pend_q <= walk_pend_d;
      green_q     <= green_d;
      yellow_q    <= yellow_d;
      walk_led_q  <= walk_led_d;
    end
  end

  // Duration register file; loads above read the pre-write value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= TW'(DEF_BASE);
      ext_q  <= TW'(DEF_EXT);
      yel_q  <= TW'(DEF_YEL);
      walk_q <= TW'(DEF_WALK);
    end else if (prog_we) begin
      unique case (prog_sel)
        2'd0: base_q <= prog_val;
        2'd1: ext_q  <= prog_val;
        2'd2: yel_q  <= prog_val;
        2'd3: walk_q <= prog_val;
        default: ;
      endcase
    end
  end

  assign green    = green_q;
  assign yellow   = yellow_q;
  assign red      = ~(green_q | yellow_q);
  assign walk_led = walk_led_q;
  assign phase    = phase_q;

endmodule
